// File: rtl/alu_control_seq.sv
// Registered ALU control decoder behind a valid/ready handshake, with an
// illegal-encoding flag, programmable-latency mult/div and synchronous flush.
module alu_control_seq #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = $clog2((MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT) + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] op,
  output logic       illegal,
  output logic       busy
);

  localparam int NFUNCT = 19;

  // Entry i of FUNCT_TAB maps to entry i of OP_TAB; functs are all distinct.
  localparam logic [NFUNCT*6-1:0] FUNCT_TAB = {
    6'b100100, 6'b001100, 6'b100101, 6'b001101, 6'b100110, 6'b001110,
    6'b100111, 6'b100000, 6'b100001, 6'b001000, 6'b100010, 6'b100011,
    6'b101010, 6'b001010, 6'b000010, 6'b000000, 6'b000011, 6'b011000,
    6'b011010
  };
  localparam logic [NFUNCT*4-1:0] OP_TAB = {
    4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0010,
    4'b0011, 4'b0101, 4'b0101, 4'b0101, 4'b0110, 4'b0110,
    4'b0111, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011,
    4'b1100
  };

  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b1011;
  localparam logic [3:0] OP_DIV = 4'b1100;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MULTI = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       op_reg, op_next;
  logic             illegal_reg, illegal_next;
  logic             out_valid_reg, out_valid_next;
  logic             busy_reg, busy_next;

  logic [NFUNCT-1:0]       hit;
  logic [NFUNCT:0][3:0]    op_acc;
  logic [3:0]              dec_op;
  logic                    dec_illegal;
  logic                    dec_multi;
  logic [CNT_W-1:0]        dec_cnt;
  logic                    accept;

  // Table match: at most one hit, so OR-accumulating the masked codes yields the match.
  assign op_acc[0] = 4'b0000;
  genvar gi;
  for (gi = 0; gi < NFUNCT; gi++) begin : g_tab
    assign hit[gi]      = (funct == FUNCT_TAB[gi*6 +: 6]);
    assign op_acc[gi+1] = op_acc[gi] | (hit[gi] ? OP_TAB[gi*4 +: 4] : 4'b0000);
  end

  always_comb begin
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    case (alu_op)
      3'b001:  dec_op = OP_ADD;
      3'b010:  dec_op = OP_SUB;
      3'b100: begin
        if (|hit) begin
          dec_op = op_acc[NFUNCT];
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // A latency of one skips MULTI entirely and lands in FULL like a single-cycle op.
  always_comb begin
    dec_multi = 1'b0;
    dec_cnt   = '0;
    if (dec_op == OP_MUL) begin
      dec_multi = (MUL_LAT > 1);
      dec_cnt   = MUL_CNT;
    end else if (dec_op == OP_DIV) begin
      dec_multi = (DIV_LAT > 1);
      dec_cnt   = DIV_CNT;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      op_reg        <= 4'b0000;
      illegal_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      op_reg        <= op_next;
      illegal_reg   <= illegal_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    op_next      = op_reg;
    illegal_next = illegal_reg;
    accept       = in_valid && in_ready;

    case (state_reg)
      S_IDLE: ;
      S_MULTI: begin
        if (cnt_reg == '0) begin
          state_next = S_FULL;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      S_FULL: begin
        if (out_ready && !accept) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (accept) begin
      op_next      = dec_op;
      illegal_next = dec_illegal;
      if (dec_multi) begin
        state_next = S_MULTI;
        cnt_next   = dec_cnt;
      end else begin
        state_next = S_FULL;
        cnt_next   = '0;
      end
    end

    // Flush wins over everything; op/illegal are deliberately left as they were.
    if (flush) begin
      state_next = S_IDLE;
      cnt_next   = '0;
    end
  end

  // Output logic: in_ready is the only combinational output.
  always_comb begin
    in_ready       = !flush &&
                     ((state_reg == S_IDLE) || ((state_reg == S_FULL) && out_ready));
    out_valid_next = (state_next == S_FULL);
    busy_next      = (state_next == S_MULTI);
  end

  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign op        = op_reg;
  assign illegal   = illegal_reg;

endmodule
